// File: rtl/chatbot_soc_debug_ocimem.sv
`default_nettype none
// ============================================================================
// Module      : chatbot_soc_debug_ocimem
// Description : Debug monitor memory controller. Executes JTAG-initiated
//               reads/writes into a small on-chip debug RAM, and shares
//               that RAM with a CPU Avalon-MM slave port (JTAG has priority).
// Revision    : 1.0 - initial release
// ============================================================================
module chatbot_soc_debug_ocimem #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_jwr  = 3'd1;
    localparam logic [2:0] c_st_jrd  = 3'd2;
    localparam logic [2:0] c_st_jcap = 3'd3;
    localparam logic [2:0] c_st_crd  = 3'd4;
    localparam logic [2:0] c_st_done = 3'd5;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;

    logic [31:0]       r_mem [0:(1<<ADDR_W)-1];
    logic [31:0]       r_ram_q;
    logic [ADDR_W-1:0] w_ram_addr;
    logic              w_ram_we;
    logic [31:0]       w_ram_wdata;
    logic [3:0]        w_ram_be;
    logic              w_wait;

    logic [31:0]       r_mon_dreg;
    logic [ADDR_W-1:0] r_mon_areg;
    logic              r_ready;
    logic              r_error;

    logic              r_pend_valid;
    logic              r_pend_wr;
    logic              r_pend_inc;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [31:0]       r_pend_data;

    logic              w_take_b;
    logic              w_take_a;
    logic              w_take_n;
    logic              w_queue;
    logic              w_accept;
    logic              w_drop;
    logic              w_unused_jdo;

    // Strobe priority b > a > no_action; losers are simply ignored.
    assign w_take_b = take_action_ocimem_b;
    assign w_take_a = take_action_ocimem_a & ~take_action_ocimem_b;
    assign w_take_n = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;

    // Only strobes that request a RAM access occupy the pending slot; an
    // address-only a-strobe never counts as an overrun. monitor_ready is low
    // exactly while an op is pending or in flight, so it doubles as busy.
    assign w_queue  = w_take_b | w_take_n | (w_take_a & jdo[34]);
    assign w_accept = w_queue & r_ready;
    assign w_drop   = w_queue & ~r_ready;

    assign w_unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_st_idle;
        else       r_state <= w_state_nxt;
    end

    // Next-state, RAM port steering and Avalon wait generation.
    always_comb begin
        w_state_nxt = r_state;
        w_wait      = 1'b1;
        w_ram_addr  = av_address;
        w_ram_we    = 1'b0;
        w_ram_wdata = av_writedata;
        w_ram_be    = av_byteenable;
        case (r_state)
            c_st_idle: begin
                if (r_pend_valid)   w_state_nxt = r_pend_wr ? c_st_jwr : c_st_jrd;
                else if (w_accept)  w_state_nxt = w_take_b ? c_st_jwr : c_st_jrd;
                else if (av_read)   w_state_nxt = c_st_crd;
                else begin
                    w_wait   = 1'b0;
                    w_ram_we = av_write;
                end
            end
            c_st_jwr: begin
                w_ram_addr  = r_pend_addr;
                w_ram_we    = 1'b1;
                w_ram_wdata = r_pend_data;
                w_ram_be    = 4'hF;
                w_state_nxt = c_st_done;
            end
            c_st_jrd: begin
                w_ram_addr  = r_pend_addr;
                w_state_nxt = c_st_jcap;
            end
            c_st_jcap: w_state_nxt = c_st_done;
            c_st_crd: begin
                w_wait      = 1'b0;
                w_state_nxt = c_st_idle;
            end
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
        // Reset aborts any op in progress, including a JWR write.
        if (reset) begin
            w_wait   = 1'b1;
            w_ram_we = 1'b0;
        end
    end

    // Single-port RAM: byte-enabled write, registered read.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_ram_be[i]) r_mem[w_ram_addr][8*i +: 8] <= w_ram_wdata[8*i +: 8];
            end
        end
        r_ram_q <= r_mem[w_ram_addr];
    end

    // JTAG monitor registers: pending slot, address/data, ready and error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mon_dreg   <= 32'h0;
            r_mon_areg   <= '0;
            r_ready      <= 1'b1;
            r_error      <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_wr    <= 1'b0;
            r_pend_inc   <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= 32'h0;
        end else begin
            if (w_accept) begin
                r_pend_valid <= 1'b1;
                r_pend_wr    <= w_take_b;
                r_pend_inc   <= w_take_n;
                r_pend_addr  <= w_take_a ? jdo[17 +: ADDR_W] : r_mon_areg;
                r_pend_data  <= jdo[34:3];
                r_ready      <= 1'b0;
            end

            case (r_state)
                c_st_jwr:  r_pend_valid <= 1'b0;
                c_st_jcap: begin
                    r_pend_valid <= 1'b0;
                    r_mon_dreg   <= r_ram_q;
                end
                c_st_done: r_ready <= 1'b1;
                default: ;
            endcase

            // An address load is honoured even when its read gets dropped.
            if (w_take_a)
                r_mon_areg <= jdo[17 +: ADDR_W];
            else if (r_state == c_st_jwr || (r_state == c_st_jrd && r_pend_inc))
                r_mon_areg <= r_mon_areg + 1'b1;

            if (w_drop)
                r_error <= 1'b1;
            else if (w_take_a && jdo[35])
                r_error <= 1'b0;
        end
    end

    assign av_waitrequest = w_wait;
    assign av_readdata    = (r_state == c_st_crd && !reset) ? r_ram_q : 32'h0;
    assign MonDReg        = r_mon_dreg;
    assign MonAReg        = r_mon_areg;
    assign monitor_ready  = r_ready;
    assign monitor_error  = r_error;

endmodule
`default_nettype wire
